binomial_decimator: RTL and testbench

//  Downstream stage of binomial_filter: consumes the filtered sample stream,

---
 rtl/binomial_decimator.sv | 93 +++++++++
 tb/tb_binomial_decimator.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/binomial_decimator.sv
// Block-averaging decimator: sums 2^LOG2_DEC valid samples, emits their mean into a small output FIFO.
// Define DECIM_ROUND_EN to round half up instead of truncating.
module binomial_decimator #(
  parameter int DW       = 8,
  parameter int LOG2_DEC = 2,
  parameter int DEPTH    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inp_valid,
  input  logic [DW-1:0] inp,
  input  logic          outp_ready,
  output logic          outp_valid,
  output logic [DW-1:0] outp,
  output logic          overflow
);
  localparam int AW = DW + LOG2_DEC;
  localparam int PW = $clog2(DEPTH);
`ifdef DECIM_ROUND_EN
  localparam logic [AW-1:0] BIAS = AW'(1) << (LOG2_DEC - 1);
`else
  localparam logic [AW-1:0] BIAS = '0;
`endif

  logic [AW-1:0]       acc_q, acc_d;
  logic [LOG2_DEC-1:0] phase_q, phase_d;
  logic [DW-1:0]       mem_q [DEPTH];
  logic [PW-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]         cnt_q, cnt_d;
  logic                ovf_q, ovf_d;

  logic          last, full, push, pop, drop;
  logic [AW-1:0] sum;
  logic [DW-1:0] result;

  // Sum cannot wrap: DEC*(2^DW-1) + DEC/2 < DEC*2^DW.
  assign sum    = acc_q + AW'(inp) + BIAS;
  assign result = DW'(sum >> LOG2_DEC);
  assign last   = inp_valid && (phase_q == '1);
  assign full   = (cnt_q == (PW+1)'(DEPTH));
  assign pop    = outp_valid && outp_ready;
  assign push   = last && (!full || pop);
  assign drop   = last && full && !pop;

  assign outp_valid = (cnt_q != '0);
  assign outp       = mem_q[rd_q];
  assign overflow   = ovf_q;

  always_comb begin
    acc_d   = acc_q;
    phase_d = phase_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q | drop;
    if (inp_valid) begin
      if (last) begin
        acc_d   = '0;
        phase_d = '0;
      end else begin
        acc_d   = acc_q + AW'(inp);
        phase_d = phase_q + LOG2_DEC'(1);
      end
    end
    if (push) wr_d = wr_q + PW'(1);
    if (pop)  rd_d = rd_q + PW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      phase_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      acc_q   <= acc_d;
      phase_q <= phase_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      if (push) mem_q[wr_q] <= result;
    end
  end
endmodule

// File: tb/tb_binomial_decimator.sv
// Randomized + directed bench for binomial_decimator against a queue-based mean/FIFO model.
module tb_binomial_decimator;
  localparam int DW = 8, L = 2, DEC = 4, DEPTH = 4;
`ifdef DECIM_ROUND_EN
  localparam int BIAS = DEC / 2;
  localparam bit RND = 1'b1;
`else
  localparam int BIAS = 0;
  localparam bit RND = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, inp_valid, outp_ready, outp_valid, overflow;
  logic [DW-1:0] inp, outp;

  binomial_decimator #(.DW(DW), .LOG2_DEC(L), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .inp_valid(inp_valid), .inp(inp),
    .outp_ready(outp_ready), .outp_valid(outp_valid), .outp(outp), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int m_q[$];
  int m_sum = 0, m_n = 0;
  bit m_ovf = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model by the same rules, then compare.
  task automatic step(input bit r, input bit v, input int d, input bit rdy);
    bit do_pop, do_push;
    int res;
    rst = r; inp_valid = v; inp = DW'(d); outp_ready = rdy;
    do_push = 1'b0; res = 0;
    if (r) begin
      m_q.delete(); m_sum = 0; m_n = 0; m_ovf = 1'b0;
    end else begin
      do_pop = rdy && (m_q.size() > 0);
      if (v) begin
        m_sum += d; m_n++;
        if (m_n == DEC) begin
          res = (m_sum + BIAS) / DEC;
          do_push = 1'b1; m_sum = 0; m_n = 0;
        end
      end
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        if (m_q.size() < DEPTH) m_q.push_back(res);
        else m_ovf = 1'b1;
      end
    end
    @(posedge clk); #1;
    chk("outp_valid", int'(outp_valid), int'(m_q.size() > 0));
    chk("overflow", int'(overflow), int'(m_ovf));
    if (m_q.size() > 0) chk("outp", int'(outp), m_q[0]);
  endtask

  initial begin
    rst = 1'b1; inp_valid = 1'b0; inp = '0; outp_ready = 1'b0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("reset_valid", int'(outp_valid), 0);
    chk("reset_outp", int'(outp), 0);
    chk("reset_ovf", int'(overflow), 0);

    // counter 0..7, consumer stalled so both results stay visible
    for (int i = 0; i < 8; i++) step(0, 1, i, 0);
    chk("ramp_first", int'(outp), RND ? 2 : 1);
    step(0, 0, 8, 1);
    chk("ramp_second", int'(outp), RND ? 6 : 5);
    step(0, 0, 9, 1);
    chk("ramp_drained", int'(outp_valid), 0);

    // valid on alternating cycles; garbage on the idle cycles must be ignored
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 10 + i, 0);
      if (i == 2) chk("toggle_early", int'(outp_valid), 0);
      if (i < 3) step(0, 0, $urandom_range(0, 255), 0);
    end
    chk("toggle_valid", int'(outp_valid), 1);
    chk("toggle_outp", int'(outp), RND ? 12 : 11);
    step(0, 0, 0, 1);

    for (int i = 0; i < 4; i++) step(0, 1, 255, 0);
    chk("max_outp", int'(outp), 255);
    step(0, 0, 0, 1);

    // five groups while stalled: fifth dropped
    for (int g = 0; g < 5; g++)
      for (int i = 0; i < 4; i++) step(0, 1, 10 * (g + 1), 0);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_head0", int'(outp), 10);
    for (int k = 1; k < 4; k++) begin
      step(0, 0, 0, 1);
      chk("ovf_head", int'(outp), 10 * (k + 1));
    end
    step(0, 0, 0, 1);
    chk("ovf_empty", int'(outp_valid), 0);
    chk("ovf_sticky", int'(overflow), 1);

    step(1, 0, 0, 0);
    // full FIFO, pop on the very cycle the fifth result arrives
    for (int g = 0; g < 4; g++)
      for (int i = 0; i < 4; i++) step(0, 1, g + 1, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 5, i == 3);
    chk("fullpop_ovf", int'(overflow), 0);
    for (int k = 0; k < 4; k++) begin
      chk("fullpop_head", int'(outp), k + 2);
      step(0, 0, 0, 1);
    end
    chk("fullpop_empty", int'(outp_valid), 0);

    // reset in the middle of a group
    step(0, 1, 100, 0);
    step(0, 1, 101, 0);
    step(1, 0, 0, 0);
    chk("midrst_valid", int'(outp_valid), 0);
    chk("midrst_ovf", int'(overflow), 0);
    for (int i = 0; i < 4; i++) step(0, 1, 8, 0);
    chk("midrst_outp", int'(outp), 8);
    step(0, 0, 0, 1);

    // random traffic with stall bursts and rare resets
    for (int c = 0; c < 3000; c++) begin
      bit rdy;
      rdy = ((c / 64) % 3 == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
      step($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 255), rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
